// File: rtl/ysyx_22041211_ifu_if.sv
// Instruction fetch unit bus bundle: control inputs, the instruction-memory
// request/response channel and the decoder-side valid/ready channel.
// The master modport is the fetch unit; the slave modport is its environment
// (execute, instruction memory and decoder seen as one peer).
interface ysyx_22041211_ifu_if #(
  parameter int DATA_LEN = 32
);
  logic                redirect_valid;
  logic [DATA_LEN-1:0] redirect_pc;
  logic                halt;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [DATA_LEN-1:0] mem_req_addr;
  logic                mem_rsp_valid;
  logic [DATA_LEN-1:0] mem_rsp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [DATA_LEN-1:0] inst;
  logic [DATA_LEN-1:0] pc;
  logic                halted;
  logic                fetch_err;

  modport master (
    input  redirect_valid, redirect_pc, halt,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output inst_valid, inst, pc,
    input  inst_ready,
    output halted, fetch_err
  );

  modport slave (
    output redirect_valid, redirect_pc, halt,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  inst_valid, inst, pc,
    output inst_ready,
    input  halted, fetch_err
  );
endinterface

// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: keeps the fetch PC, issues one instruction-memory
// request at a time and hands each returned word (with its PC) to decode.
// Redirects from execute and a permanent halt are honoured without ever
// abandoning a request the memory has already accepted.
// Optional feature macro: YSYX_22041211_IFU_ALIGN_CHK_EN -- when defined, a
// redirect to a non-word-aligned target raises a sticky fetch_err and stops
// fetching like a halt; when undefined the low two target bits are ignored.
module ysyx_22041211_ifu #(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RESET_PC = DATA_LEN'(32'h8000_0000)
) (
  input logic                    clk,
  input logic                    rst_n,
  ysyx_22041211_ifu_if.master    bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]          state_reg, state_next;
  logic [DATA_LEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [DATA_LEN-1:0] redir_pc_reg, redir_pc_next;
  logic [DATA_LEN-1:0] inst_reg, inst_next;
  logic [DATA_LEN-1:0] pc_reg, pc_next;
  logic                redir_pend_reg, redir_pend_next;
  logic                halt_pend_reg, halt_pend_next;
  logic                fetch_err_reg, fetch_err_next;

  logic                misaligned;
  logic                stop_req;
  logic                redir_ok;
  logic [DATA_LEN-1:0] redir_target;

`ifdef YSYX_22041211_IFU_ALIGN_CHK_EN
  // A misaligned target is never fetched; it is turned into a stop request.
  assign misaligned   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redir_target = bus.redirect_pc;
`else
  assign misaligned   = 1'b0;
  assign redir_target = bus.redirect_pc & ~DATA_LEN'(3);
`endif

  // Halt (or a misaligned redirect) always beats an ordinary redirect.
  assign stop_req = bus.halt || misaligned;
  assign redir_ok = bus.redirect_valid && !stop_req;

  // Next-state and datapath update for the fetch sequencer.
  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    redir_pc_next   = redir_pc_reg;
    redir_pend_next = redir_pend_reg;
    halt_pend_next  = halt_pend_reg;
    inst_next       = inst_reg;
    pc_next         = pc_reg;
    fetch_err_next  = fetch_err_reg | misaligned;

    case (state_reg)
      S_IDLE: begin
        if (stop_req) begin
          state_next = S_HALT;
        end else begin
          state_next = S_REQ;
          if (redir_ok) fetch_pc_next = redir_target;
        end
      end

      S_REQ: begin
        if (stop_req && !bus.mem_req_ready) begin
          // Request not yet accepted: it can simply be withdrawn.
          state_next = S_HALT;
        end else begin
          if (stop_req) begin
            halt_pend_next = 1'b1;
          end else if (redir_ok) begin
            redir_pend_next = 1'b1;
            redir_pc_next   = redir_target;
          end
          if (bus.mem_req_ready) state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (halt_pend_reg || stop_req) begin
            // Owed response has arrived and is dropped; safe to stop now.
            state_next      = S_HALT;
            redir_pend_next = 1'b0;
          end else if (redir_pend_reg || redir_ok) begin
            // Word belongs to the abandoned path; restart at the target.
            fetch_pc_next   = redir_ok ? redir_target : redir_pc_reg;
            redir_pend_next = 1'b0;
            state_next      = S_REQ;
          end else begin
            inst_next     = bus.mem_rsp_data;
            pc_next       = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + DATA_LEN'(4);
            state_next    = S_HOLD;
          end
        end else if (stop_req) begin
          halt_pend_next = 1'b1;
        end else if (redir_ok) begin
          redir_pend_next = 1'b1;
          redir_pc_next   = redir_target;
        end
      end

      S_HOLD: begin
        if (stop_req) begin
          state_next = S_HALT;
        end else if (redir_ok) begin
          // Held word is dropped, or counts as consumed if inst_ready is high.
          fetch_pc_next = redir_target;
          state_next    = S_REQ;
        end else if (bus.inst_ready) begin
          state_next = S_REQ;
        end
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any transaction in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= RESET_PC;
      redir_pc_reg   <= RESET_PC;
      redir_pend_reg <= 1'b0;
      halt_pend_reg  <= 1'b0;
      inst_reg       <= '0;
      pc_reg         <= RESET_PC;
      fetch_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      redir_pc_reg   <= redir_pc_next;
      redir_pend_reg <= redir_pend_next;
      halt_pend_reg  <= halt_pend_next;
      inst_reg       <= inst_next;
      pc_reg         <= pc_next;
      fetch_err_reg  <= fetch_err_next;
    end
  end

  // Every output is a register or a decode of the state register only.
  assign bus.mem_req_valid = (state_reg == S_REQ);
  assign bus.mem_req_addr  = fetch_pc_reg;
  assign bus.inst_valid    = (state_reg == S_HOLD);
  assign bus.inst          = inst_reg;
  assign bus.pc            = pc_reg;
  assign bus.halted        = (state_reg == S_HALT);
  assign bus.fetch_err     = fetch_err_reg;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Bench for ysyx_22041211_ifu: a transaction-level model (expected fetch
// address, outstanding memory response, presented instruction, halted flag)
// plus a small memory responder, checked every cycle, and directed literal
// checks at hand-computed cycles. Honours YSYX_22041211_IFU_ALIGN_CHK_EN.
module tb_ysyx_22041211_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk;
  logic rst_n;

  ysyx_22041211_ifu_if #(.DATA_LEN(32)) bus ();

  ysyx_22041211_ifu #(
    .DATA_LEN (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Memory knobs set by the directed sequence
  int rsp_lat   = 0;
  int stall_len = 0;
  int stall_tag = 0;

  // Model state
  logic [31:0] m_addr, m_pend, m_inst, m_pc, m_owe_addr;
  bit          m_idle, m_hold, m_halted, m_owe, m_drop, m_stop_after, m_err;
  int          m_lat, stall_cnt, tag_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h8000_0000: word_at = 32'h0000_0413;
      32'h8000_0004: word_at = 32'h0010_0073;
      default:       word_at = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = RST_PC; m_pend = '0; m_inst = '0; m_pc = RST_PC; m_owe_addr = '0;
    m_idle = 1'b1; m_hold = 1'b0; m_halted = 1'b0; m_owe = 1'b0;
    m_drop = 1'b0; m_stop_after = 1'b0; m_err = 1'b0;
    m_lat = 0; stall_cnt = 0; tag_seen = stall_tag;
  endtask

  // Model + memory responder: compare, drive memory, then advance one cycle
  initial begin : model
    bit          want_req, acc, rsp, redir, mis, stop;
    logic [31:0] tgt;
    model_reset();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        model_reset();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
      end else begin
        want_req = !m_idle && !m_halted && !m_hold && !m_owe;
        chk1("m_halted", bus.halted, m_halted);
        chk1("m_inst_valid", bus.inst_valid, m_hold);
        if (m_hold) begin
          chk32("m_inst", bus.inst, m_inst);
          chk32("m_pc", bus.pc, m_pc);
        end
        chk1("m_req_valid", bus.mem_req_valid, want_req);
        if (want_req) chk32("m_req_addr", bus.mem_req_addr, m_addr);
        chk1("m_fetch_err", bus.fetch_err, m_err);

        if (stall_tag != tag_seen) begin
          stall_cnt = stall_len;
          tag_seen  = stall_tag;
        end
        if (want_req && stall_cnt > 0) begin
          bus.mem_req_ready = 1'b0;
          stall_cnt--;
        end else begin
          bus.mem_req_ready = 1'b1;
        end
        rsp = m_owe && (m_lat == 0);
        bus.mem_rsp_valid = rsp;
        bus.mem_rsp_data  = rsp ? word_at(m_owe_addr) : 32'hDEAD_BEEF;

        acc   = want_req && bus.mem_req_ready;
        redir = bus.redirect_valid;
        mis   = 1'b0;
`ifdef YSYX_22041211_IFU_ALIGN_CHK_EN
        mis = redir && (bus.redirect_pc[1:0] != 2'b00);
`endif
        stop = bus.halt || mis;
        tgt  = bus.redirect_pc & 32'hFFFF_FFFC;
        if (mis) m_err = 1'b1;

        if (m_halted) begin
          // stays stopped until reset
        end else if (m_idle) begin
          m_idle = 1'b0;
          if (stop) m_halted = 1'b1;
          else if (redir) m_addr = tgt;
        end else if (m_hold) begin
          if (stop) begin
            m_hold = 1'b0; m_halted = 1'b1;
          end else if (redir) begin
            m_hold = 1'b0; m_addr = tgt;
          end else if (bus.inst_ready) begin
            m_hold = 1'b0;
          end
        end else if (!m_owe) begin
          if (stop && !acc) begin
            m_halted = 1'b1;
          end else begin
            if (stop) m_stop_after = 1'b1;
            else if (redir) begin m_drop = 1'b1; m_pend = tgt; end
            if (acc) begin m_owe = 1'b1; m_lat = rsp_lat; m_owe_addr = m_addr; end
          end
        end else begin
          if (stop) m_stop_after = 1'b1;
          else if (redir) begin m_drop = 1'b1; m_pend = tgt; end
          if (rsp) begin
            m_owe = 1'b0;
            if (m_stop_after) m_halted = 1'b1;
            else if (m_drop) begin m_drop = 1'b0; m_addr = m_pend; end
            else begin
              m_hold = 1'b1; m_inst = word_at(m_addr); m_pc = m_addr; m_addr = m_addr + 32'd4;
            end
          end else begin
            m_lat--;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Directed sequence; cycle numbers count negedges after reset release
  initial begin : stim
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    bus.inst_ready     = 1'b1;
    repeat (3) tick();
    chk1 ("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk32("rst_req_addr", bus.mem_req_addr, 32'h8000_0000);
    chk1 ("rst_inst_valid", bus.inst_valid, 1'b0);
    chk32("rst_inst", bus.inst, 32'h0);
    chk32("rst_pc", bus.pc, 32'h8000_0000);
    chk1 ("rst_halted", bus.halted, 1'b0);
    chk1 ("rst_fetch_err", bus.fetch_err, 1'b0);
    rst_n = 1'b1;                                   // c0
    tick();                                         // c1
    chk1 ("c1_req_valid", bus.mem_req_valid, 1'b1);
    chk32("c1_req_addr", bus.mem_req_addr, 32'h8000_0000);
    tick();                                         // c2
    chk1 ("c2_inst_valid", bus.inst_valid, 1'b0);
    tick();                                         // c3
    chk1 ("c3_inst_valid", bus.inst_valid, 1'b1);
    chk32("c3_pc", bus.pc, 32'h8000_0000);
    chk32("c3_inst", bus.inst, 32'h0000_0413);
    tick();                                         // c4
    chk1 ("c4_req_valid", bus.mem_req_valid, 1'b1);
    chk32("c4_req_addr", bus.mem_req_addr, 32'h8000_0004);
    tick(); tick();                                 // c6
    chk1 ("c6_inst_valid", bus.inst_valid, 1'b1);
    chk32("c6_pc", bus.pc, 32'h8000_0004);
    chk32("c6_inst", bus.inst, 32'h0010_0073);
    bus.inst_ready = 1'b0;                          // decoder stalls c6..c10
    for (int i = 0; i < 5; i++) begin               // c7..c11
      tick();
      chk1 ("stall_inst_valid", bus.inst_valid, 1'b1);
      chk32("stall_pc", bus.pc, 32'h8000_0004);
      chk32("stall_inst", bus.inst, 32'h0010_0073);
      chk1 ("stall_no_req", bus.mem_req_valid, 1'b0);
    end
    stall_len = 4; stall_tag++;                     // memory not ready c12..c15
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin               // c12..c16
      tick();
      chk1 ("memstall_req_valid", bus.mem_req_valid, 1'b1);
      chk32("memstall_req_addr", bus.mem_req_addr, 32'h8000_0008);
    end
    tick();                                         // c17
    chk1 ("c17_inst_valid", bus.inst_valid, 1'b0);
    tick();                                         // c18
    chk1 ("c18_inst_valid", bus.inst_valid, 1'b1);
    chk32("c18_pc", bus.pc, 32'h8000_0008);
    rsp_lat = 2;
    tick();                                         // c19
    chk32("c19_req_addr", bus.mem_req_addr, 32'h8000_000C);
    tick();                                         // c20: WAIT
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();                                         // c21
    bus.redirect_valid = 1'b0;
    rsp_lat = 0;
    tick();                                         // c22: discarded response
    chk1 ("c22_inst_valid", bus.inst_valid, 1'b0);
    tick();                                         // c23
    chk1 ("c23_inst_valid", bus.inst_valid, 1'b0);
    chk1 ("c23_req_valid", bus.mem_req_valid, 1'b1);
    chk32("c23_req_addr", bus.mem_req_addr, 32'h8000_0100);
    tick(); tick();                                 // c25: HOLD
    chk1 ("c25_inst_valid", bus.inst_valid, 1'b1);
    chk32("c25_pc", bus.pc, 32'h8000_0100);
    chk32("c25_inst", bus.inst, word_at(32'h8000_0100));
    bus.redirect_valid = 1'b1;                      // redirect with inst_ready high
    bus.redirect_pc    = 32'h8000_0200;
    tick();                                         // c26
    bus.redirect_valid = 1'b0;
    chk1 ("c26_inst_valid", bus.inst_valid, 1'b0);
    chk32("c26_req_addr", bus.mem_req_addr, 32'h8000_0200);
    tick();                                         // c27
    chk1 ("c27_inst_valid", bus.inst_valid, 1'b0);
    tick();                                         // c28
    chk32("c28_pc", bus.pc, 32'h8000_0200);
    rsp_lat = 1;
    tick();                                         // c29
    chk32("c29_req_addr", bus.mem_req_addr, 32'h8000_0204);
    tick();                                         // c30: WAIT
    bus.halt = 1'b1;
    tick();                                         // c31: response discarded
    bus.halt = 1'b0;
    rsp_lat = 0;
    chk1 ("c31_halted", bus.halted, 1'b0);
    for (int i = 0; i < 4; i++) begin               // c32..c35
      tick();
      chk1 ("halt_halted", bus.halted, 1'b1);
      chk1 ("halt_no_req", bus.mem_req_valid, 1'b0);
      chk1 ("halt_inst_valid", bus.inst_valid, 1'b0);
    end
    rst_n = 1'b0;
    tick();
    chk1 ("rst2_halted", bus.halted, 1'b0);
    tick();
    rst_n = 1'b1;                                   // c0
    tick();                                         // c1
    chk1 ("r_c1_req_valid", bus.mem_req_valid, 1'b1);
    chk32("r_c1_req_addr", bus.mem_req_addr, 32'h8000_0000);
    tick(); tick();                                 // c3
    chk32("r_c3_pc", bus.pc, 32'h8000_0000);
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    tick();                                         // c4
    bus.redirect_valid = 1'b0;
`ifdef YSYX_22041211_IFU_ALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin               // c4..c6
      chk1("mis_fetch_err", bus.fetch_err, 1'b1);
      chk1("mis_halted", bus.halted, 1'b1);
      chk1("mis_no_req", bus.mem_req_valid, 1'b0);
      tick();
    end
`else
    chk1 ("mis_fetch_err", bus.fetch_err, 1'b0);
    chk1 ("mis_req_valid", bus.mem_req_valid, 1'b1);
    chk32("mis_req_addr", bus.mem_req_addr, 32'h8000_0100);
    tick();
`endif
    rst_n = 1'b0;
    tick();
    chk1("end_fetch_err", bus.fetch_err, 1'b0);
    chk1("end_halted", bus.halted, 1'b0);
    tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Time bound in case the sequence ever stalls
  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got timeout, expected sequence end");
    $fatal(1, "timeout");
  end
endmodule
